// File: rtl/register_scoreboard_if.sv
// Decode/completion bundle for the register scoreboard.
// Latency: n/a (signal bundle only).
// Backpressure: none here; the scoreboard answers with a combinational stall.
//
// slave  : seen by the scoreboard (decode + completion in, stall/status out)
// master : seen by the pipeline driving decode and long-latency completion
interface register_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 16
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int OW = $clog2(NUM_REGS) + 1;

    // decode stage
    logic          ID_valid;
    logic [RW-1:0] ID_Rs1;
    logic [RW-1:0] ID_Rs2;
    logic          ID_uses_rs1;
    logic          ID_uses_rs2;
    logic [RW-1:0] ID_Rd;
    logic          ID_RegWrite;
    logic          ID_long_latency;
    logic          flush;

    // long-latency completion / squash
    logic          LL_done;
    logic [RW-1:0] LL_Rd;
    logic          LL_kill;
    logic [RW-1:0] LL_kill_Rd;

    // scoreboard results
    logic                stall;
    logic [NUM_REGS-1:0] pending_mask;
    logic [OW-1:0]       outstanding;
    logic [CNT_W-1:0]    stall_cycles;
    logic                hazard_timeout;

    modport slave (
        input  ID_valid, ID_Rs1, ID_Rs2, ID_uses_rs1, ID_uses_rs2,
        input  ID_Rd, ID_RegWrite, ID_long_latency, flush,
        input  LL_done, LL_Rd, LL_kill, LL_kill_Rd,
        output stall, pending_mask, outstanding, stall_cycles, hazard_timeout
    );

    modport master (
        output ID_valid, ID_Rs1, ID_Rs2, ID_uses_rs1, ID_uses_rs2,
        output ID_Rd, ID_RegWrite, ID_long_latency, flush,
        output LL_done, LL_Rd, LL_kill, LL_kill_Rd,
        input  stall, pending_mask, outstanding, stall_cycles, hazard_timeout
    );
endinterface

// File: rtl/register_scoreboard.sv
// Pending-destination scoreboard for long-latency ops; drives the decode stall.
// Latency: stall is combinational on decode inputs; pending bits update at the next edge.
// Backpressure: stall holds PC and IF/ID; no internal buffering, nothing is ever dropped.
//
// Ports:
//   clk   - core clock, rising edge
//   rst_n - asynchronous active-low reset, clears all state immediately
//   sb    - register_scoreboard_if.slave: decode operands/destination, flush,
//           LL completion and kill in; stall, pending_mask, outstanding,
//           stall_cycles and the sticky hazard_timeout watchdog flag out
module register_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic clk,
    input  logic rst_n,
    register_scoreboard_if.slave sb
);
    localparam int RW    = $clog2(NUM_REGS);
    localparam int OW    = RW + 1;
    localparam int RUN_W = $clog2(TIMEOUT + 1);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] eff;
    logic [OW-1:0]       outstanding_q, outstanding_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                timeout_q, timeout_d;

    logic hit_rs1, hit_rs2, hit_rd;
    logic stall;
    logic issue;

    // Effective pending: a result written back (or killed) this cycle no longer
    // blocks anyone; the WB bypass supplies the data to a released consumer.
    always_comb begin
        eff = pending_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (sb.LL_done && (sb.LL_Rd == RW'(r))) begin
                eff[r] = 1'b0;
            end
            if (sb.LL_kill && (sb.LL_kill_Rd == RW'(r))) begin
                eff[r] = 1'b0;
            end
        end
        eff[0] = 1'b0;
    end

    // The Rd term is the WAW guard: at most one outstanding producer per register.
    always_comb begin
        hit_rs1 = sb.ID_uses_rs1 && (sb.ID_Rs1 != '0) && eff[sb.ID_Rs1];
        hit_rs2 = sb.ID_uses_rs2 && (sb.ID_Rs2 != '0) && eff[sb.ID_Rs2];
        hit_rd  = sb.ID_RegWrite && (sb.ID_Rd  != '0) && eff[sb.ID_Rd];
        stall   = sb.ID_valid && !sb.flush && (hit_rs1 || hit_rs2 || hit_rd);
        issue   = sb.ID_valid && !sb.flush && !stall && sb.ID_RegWrite &&
                  sb.ID_long_latency && (sb.ID_Rd != '0);
    end

    // Next pending set starts from eff so clears apply first; an issue to a
    // register being cleared this same cycle therefore wins and stays set.
    always_comb begin
        pending_d = eff;
        if (issue) begin
            pending_d[sb.ID_Rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        outstanding_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            outstanding_d = outstanding_d + OW'(pending_d[r]);
        end
    end

    // Stall-cycle counter (saturating) and consecutive-stall watchdog.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        run_d = run_q;
        if (!stall) begin
            run_d = '0;
        end else if (run_q != RUN_W'(TIMEOUT)) begin
            run_d = run_q + 1'b1;
        end

        // Fires on the edge where the run of stalls reaches TIMEOUT; sticky.
        timeout_d = timeout_q || (stall && (run_d == RUN_W'(TIMEOUT)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            stall_cnt_q   <= '0;
            run_q         <= '0;
            timeout_q     <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            stall_cnt_q   <= stall_cnt_d;
            run_q         <= run_d;
            timeout_q     <= timeout_d;
        end
    end

    // During reset pending_q is zero, so stall is already forced low.
    assign sb.stall          = stall;
    assign sb.pending_mask   = pending_q;
    assign sb.outstanding    = outstanding_q;
    assign sb.stall_cycles   = stall_cnt_q;
    assign sb.hazard_timeout = timeout_q;

endmodule
